// File: rtl/stat_fifo_pkg.sv
// Shared FIFO defaults for the UART TX/RX buffer instances.
package stat_fifo_pkg;

    localparam int unsigned DEF_B     = 8;
    localparam int unsigned DEF_W     = 4;
    localparam int unsigned DEF_AE_TH = 2;

    // Default almost-full threshold: two entries below a 2**w deep queue.
    function automatic int unsigned def_af_th(input int unsigned w);
        return (32'd1 << w) - 32'd2;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: 2**W x B, synchronous write, asynchronous read, no reset.
module fifo_mem #(
    parameter int unsigned B = 8,
    parameter int unsigned W = 4
)(
    input  logic         clk,
    input  logic         we,
    input  logic [W-1:0] waddr,
    input  logic [B-1:0] wdata,
    input  logic [W-1:0] raddr,
    output logic [B-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** W;

    logic [B-1:0] mem [DEPTH];

    // Write port; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stat_fifo.sv
// First-word-fall-through FIFO with registered status flags and sticky errors.
module stat_fifo
    import stat_fifo_pkg::*;
#(
    parameter int unsigned B     = DEF_B,
    parameter int unsigned W     = DEF_W,
    parameter int unsigned AF_TH = def_af_th(W),
    parameter int unsigned AE_TH = DEF_AE_TH
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         rd,
    input  logic         wr,
    input  logic [B-1:0] wr_data,
    input  logic         err_clr,
    output logic [B-1:0] rd_data,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   count,
    output logic         ovf,
    output logic         udf
);

    localparam int unsigned CW    = W + 1;
    localparam logic [W:0]  DEPTH = CW'(2 ** W);
    localparam logic [W:0]  AF_C  = CW'(AF_TH);
    localparam logic [W:0]  AE_C  = CW'(AE_TH);

    logic [W-1:0] wr_ptr;
    logic [W-1:0] rd_ptr;
    logic [W:0]   count_nxt;
    logic         wr_acc;
    logic         rd_acc;
    logic         mem_we;
    logic         ovf_set;
    logic         udf_set;

    // Accept decisions and next occupancy; a full FIFO accepts a push paired with a pop.
    always_comb begin
        wr_acc    = wr & (~full | rd);
        rd_acc    = rd & ~empty;
        ovf_set   = wr & ~rd & full;
        udf_set   = rd & empty;
        mem_we    = wr_acc & ~clr & reset;
        count_nxt = count;
        if (wr_acc && !rd_acc) begin
            count_nxt = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - CW'(1);
        end
    end

    // Pointers, occupancy, status flags and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            ovf          <= 1'b0;
            udf          <= 1'b0;
        end else if (clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + W'(1);
            end
            count        <= count_nxt;
            empty        <= (count_nxt == '0);
            full         <= (count_nxt == DEPTH);
            almost_empty <= (count_nxt <= AE_C);
            almost_full  <= (count_nxt >= AF_C);
            ovf          <= ovf_set | (ovf & ~err_clr);
            udf          <= udf_set | (udf & ~err_clr);
        end
    end

    fifo_mem #(
        .B (B),
        .W (W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_stat_fifo.sv
// Directed self-checking bench for stat_fifo at default parameters (B=8, W=4).
module tb_stat_fifo;

    logic       clk;
    logic       reset;
    logic       clr;
    logic       rd;
    logic       wr;
    logic [7:0] wr_data;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [4:0] count;
    logic       ovf;
    logic       udf;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q [$];
    logic [7:0] exp_head;

    stat_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .clr          (clr),
        .rd           (rd),
        .wr           (wr),
        .wr_data      (wr_data),
        .err_clr      (err_clr),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .ovf          (ovf),
        .udf          (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd = 1'b0; wr = 1'b0; clr = 1'b0; err_clr = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"},  32'(full),  32'd0);
        chk({tag, "_ae"},    32'(almost_empty), 32'd1);
        chk({tag, "_af"},    32'(almost_full),  32'd0);
        chk({tag, "_ovf"},   32'(ovf), 32'd0);
        chk({tag, "_udf"},   32'(udf), 32'd0);
    endtask

    initial begin
        reset = 1'b0; wr_data = 8'h00;
        idle();
        #12;
        chk_reset_state("rst");
        tick();
        reset = 1'b1;
        tick();

        // Three pushes, then pop in order.
        wr = 1'b1; wr_data = 8'h11; tick();
        chk("p1_count", 32'(count), 32'd1);
        chk("p1_head",  32'(rd_data), 32'h11);
        chk("p1_empty", 32'(empty), 32'd0);
        wr_data = 8'h22; tick();
        wr_data = 8'h33; tick();
        idle();
        chk("p3_count", 32'(count), 32'd3);
        chk("p3_head",  32'(rd_data), 32'h11);
        chk("p3_ae",    32'(almost_empty), 32'd0);
        rd = 1'b1;
        chk("pop0", 32'(rd_data), 32'h11); tick();
        chk("pop1", 32'(rd_data), 32'h22); tick();
        chk("pop2", 32'(rd_data), 32'h33); tick();
        idle();
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_udf",   32'(udf), 32'd0);

        // Fill all 16 entries (pointers start at 3, so storage wraps).
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; wr_data = 8'h40 + 8'(i);
            q.push_back(wr_data);
            tick();
            if (i == 1)  chk("c2_ae",   32'(almost_empty), 32'd1);
            if (i == 2)  chk("c3_ae",   32'(almost_empty), 32'd0);
            if (i == 12) chk("c13_af",  32'(almost_full),  32'd0);
            if (i == 13) chk("c14_af",  32'(almost_full),  32'd1);
            if (i == 13) chk("c14_full", 32'(full), 32'd0);
        end
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_full",  32'(full), 32'd1);
        chk("fill_ovf",   32'(ovf), 32'd0);
        wr_data = 8'hFF; tick();
        wr = 1'b0;
        chk("ovf_set",   32'(ovf), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_head",  32'(rd_data), 32'h40);

        // Simultaneous push/pop on a full FIFO across pointer wrap.
        rd = 1'b1; wr = 1'b1; wr_data = 8'hA5;
        for (int i = 0; i < 20; i++) begin
            exp_head = q.pop_front();
            q.push_back(8'hA5);
            chk("rw_head", 32'(rd_data), 32'(exp_head));
            tick();
            chk("rw_count", 32'(count), 32'd16);
            chk("rw_full",  32'(full), 32'd1);
        end
        idle();
        chk("rw_ovf_sticky", 32'(ovf), 32'd1);

        err_clr = 1'b1; tick(); idle();
        chk("errclr_ovf", 32'(ovf), 32'd0);

        rd = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        idle();
        chk("drain2_empty", 32'(empty), 32'd1);
        chk("drain2_udf",   32'(udf), 32'd0);

        // Push and pop together while empty.
        rd = 1'b1; wr = 1'b1; wr_data = 8'h5A; tick(); idle();
        chk("rwe_udf",   32'(udf), 32'd1);
        chk("rwe_count", 32'(count), 32'd1);
        chk("rwe_head",  32'(rd_data), 32'h5A);
        chk("rwe_empty", 32'(empty), 32'd0);

        wr = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wr_data = 8'(i); tick();
        end
        idle();
        chk("c5_count", 32'(count), 32'd5);

        // Flush wins over a concurrent write; sticky flags are held.
        clr = 1'b1; wr = 1'b1; wr_data = 8'hEE; tick(); idle();
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_empty", 32'(empty), 32'd1);
        chk("clr_ae",    32'(almost_empty), 32'd1);
        chk("clr_udf",   32'(udf), 32'd1);
        chk("clr_ovf",   32'(ovf), 32'd0);

        // A new underflow beats err_clr in the same cycle.
        err_clr = 1'b1; rd = 1'b1; tick(); idle();
        chk("errclr_udf_wins", 32'(udf), 32'd1);
        err_clr = 1'b1; tick(); idle();
        chk("errclr_udf", 32'(udf), 32'd0);

        // Reset in the middle of a burst at count 7.
        rd = 1'b1; tick(); idle();
        wr = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wr_data = 8'h70 + 8'(i); tick();
        end
        chk("pre_rst_count", 32'(count), 32'd7);
        chk("pre_rst_udf",   32'(udf), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_state("async_rst");
        tick();
        chk("rst_hold_count", 32'(count), 32'd0);
        reset = 1'b1; idle();
        tick();
        chk("post_rst_empty", 32'(empty), 32'd1);
        chk("post_rst_count", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stat_fifo.md
STAT_FIFO -- requirements
Module: stat_fifo

Interface
REQ-001 The block SHALL have parameter B, default 8, data word width in bits.
REQ-002 The block SHALL have parameter W, default 4, address width; depth = 2**W entries.
REQ-003 The block SHALL have parameter AF_TH, default 2**W-2, almost-full threshold in entries.
REQ-004 The block SHALL have parameter AE_TH, default 2, almost-empty threshold in entries.
REQ-005 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port clr  input  1  synchronous flush.
REQ-008 The block SHALL have port rd  input  1  read/pop request.
REQ-009 The block SHALL have port wr  input  1  write/push request.
REQ-010 The block SHALL have port wr_data  input  B  data to push.
REQ-011 The block SHALL have port err_clr  input  1  clears sticky error flags.
REQ-012 The block SHALL have port rd_data  output  B  head-of-queue word, first-word-fall-through.
REQ-013 The block SHALL have port empty  output  1  no entries stored.
REQ-014 The block SHALL have port full  output  1  2**W entries stored.
REQ-015 The block SHALL have port almost_empty  output  1  count <= AE_TH.
REQ-016 The block SHALL have port almost_full  output  1  count >= AF_TH.
REQ-017 The block SHALL have port count  output  W+1  current occupancy, 0..2**W.
REQ-018 The block SHALL have port ovf  output  1  sticky overflow flag.
REQ-019 The block SHALL have port udf  output  1  sticky underflow flag.

Function
REQ-020 rd_data SHALL be combinational from the storage entry at the read pointer; zero-cycle read latency.
REQ-021 Accepted write (wr & (~full | rd)) SHALL store wr_data at write pointer and advance it mod 2**W at the clock edge.
REQ-022 Accepted read (rd & ~empty) SHALL advance the read pointer mod 2**W at the clock edge.
REQ-023 count SHALL be a register: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
REQ-024 empty, full, almost_empty, almost_full SHALL be registered state, updated in the same edge as count, consistent with the next count value.
REQ-025 rd & wr while empty: write accepted, read ignored, udf set; count 0->1 next cycle.
REQ-026 rd & wr while full: both accepted, count stays 2**W, full stays 1, ovf not set.
REQ-027 wr & ~rd while full: write dropped, storage and pointers unchanged, ovf set.
REQ-028 rd & ~wr while empty: pointers unchanged, udf set.
REQ-029 clr SHALL take priority over rd/wr: pointers and count to 0, empty=1, full=0, almost_empty=1, almost_full=0; storage contents, ovf, udf untouched.
REQ-030 err_clr SHALL clear ovf and udf next edge; a new overflow/underflow in the same cycle SHALL win (flag set).
REQ-031 Pointer wrap-around SHALL be seamless: all 2**W entries usable, no reserved slot.
REQ-032 Parameters SHALL satisfy 0 <= AE_TH < AF_TH <= 2**W; other values are unsupported.

Reset
REQ-033 On reset low, asynchronously: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, ovf=0, udf=0.
REQ-034 Storage array SHALL NOT be reset; rd_data is undefined until first write.
REQ-035 Reset asserted mid-operation SHALL discard all stored entries; no write completes in the reset cycle.

Structure
REQ-036 Default B/W constants and threshold defaults SHALL live in the shared UART package/header, used by UART TX/RX buffer instances.
REQ-037 Storage SHALL be one sub-module fifo_mem (2**W x B, synchronous write, asynchronous read); control logic stays in stat_fifo.

Verification
REQ-038 Reset, then push 0x11,0x22,0x33 -> count=3, rd_data=0x11, empty=0; pop 3 -> 0x11,0x22,0x33 in order, empty=1.
REQ-039 Push 16 words (W=4) -> full=1, almost_full=1 at count 14; 17th push dropped, ovf=1, count=16.
REQ-040 Full FIFO, rd&wr with 0xA5 for 20 cycles -> count stays 16, ordering preserved across pointer wrap.
REQ-041 Empty FIFO, rd&wr with 0x5A -> udf=1, count=1, rd_data=0x5A next cycle.
REQ-042 Count=5, assert clr with wr=1 -> count=0, empty=1; ovf/udf unchanged; err_clr with rd on empty -> udf stays 1.
REQ-043 Assert reset at count=7 mid-burst -> all flags/count at reset values immediately, before next clk edge.
